// File: rtl/clk_period_meter.sv
// Clock period meter: counts clk cycles between edges of a slow input and
// reports them as a divider terminal count, with lock and timeout status.
module clk_period_meter #(
    parameter int CNT_W       = 26,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0,
    parameter int LOCK_COUNT  = 4,
    parameter int TOLERANCE   = 0,
    parameter int TIMEOUT     = 1 << 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);
    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TOL = CNT_W'(TOLERANCE);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    localparam logic [MC_W-1:0] LOCK_N = MC_W'(LOCK_COUNT);
    localparam logic [MC_W-1:0] ONE = MC_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        MEAS,
        LOCKED
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] prev, prev_n;
    logic [CNT_W-1:0] period_n;
    logic [CNT_W-1:0] diff;
    logic [MC_W-1:0]  match_cnt, match_n, run;
    logic             valid_n, timeout_n;
    logic             s, s_d, edge_q, qual, is_match;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign s = sig_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync;
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync <= '0;
                end else begin
                    sync <= SYNC_STAGES'({sync, sig_in});
                end
            end
            assign s = sync[SYNC_STAGES-1];
        end
    endgenerate

    assign qual   = (EDGE_MODE == 0) ? (s ^ s_d) : (s & ~s_d);
    assign locked = (state == LOCKED);

    always_comb begin
        state_n   = state;
        cnt_n     = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        prev_n    = prev;
        match_n   = match_cnt;
        period_n  = period_out;
        valid_n   = 1'b0;
        timeout_n = timeout;
        diff      = (cnt >= prev) ? cnt - prev : prev - cnt;
        is_match  = (diff <= TOL);
        // match_cnt==0 marks the first measurement after arming
        if (match_cnt == '0 || !is_match) begin
            run = ONE;
        end else if (match_cnt == LOCK_N) begin
            run = LOCK_N;
        end else begin
            run = match_cnt + ONE;
        end
        if (edge_q) begin
            cnt_n     = '0;
            timeout_n = 1'b0;
            if (state == IDLE) begin
                state_n = MEAS;
                match_n = '0;
            end else begin
                period_n = cnt;
                valid_n  = 1'b1;
                prev_n   = cnt;
                match_n  = run;
                state_n  = (run == LOCK_N) ? LOCKED : MEAS;
            end
        end else if (TIMEOUT != 0 && state != IDLE && cnt == TO_LAST) begin
            state_n   = IDLE;
            timeout_n = 1'b1;
            match_n   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_d        <= 1'b0;
            edge_q     <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            prev       <= '0;
            match_cnt  <= '0;
            period_out <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            s_d        <= s;
            edge_q     <= qual;
            state      <= state_n;
            cnt        <= cnt_n;
            prev       <= prev_n;
            match_cnt  <= match_n;
            period_out <= period_n;
            meas_valid <= valid_n;
            timeout    <= timeout_n;
        end
    end
endmodule
